// File: rtl/uart_tx_drain.sv
// UART transmitter that pops bytes from an upstream queue and sends 8 data bits, LSB first.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       q_avail,
    output logic       q_re,
    input  logic [7:0] q_data,
    output logic       tx,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd5
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    state_t      state_r;
    state_t      state_s;
    logic [15:0] baud_r;
    logic [15:0] baud_s;
    logic [2:0]  bit_r;
    logic [2:0]  bit_s;
    logic [2:0]  bit_inc_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_s;
    logic        tx_r;
    logic        tx_s;
    logic        busy_r;
    logic        q_re_s;
    logic        baud_end_s;

    assign bit_inc_s  = bit_r + 3'd1;
    assign baud_end_s = (baud_r == BAUD_LAST);

    // Next-state, counters and the value tx will take after the coming edge
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r + 16'd1;
        bit_s   = bit_r;
        shift_s = shift_r;
        tx_s    = tx_r;
        q_re_s  = 1'b0;
        case (state_r)
            IDLE: begin
                baud_s = 16'd0;
                tx_s   = 1'b1;
                // Pop is decoded combinationally so a waiting byte is taken in the very first IDLE cycle
                if (q_avail && !rst) begin
                    q_re_s  = 1'b1;
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                shift_s = q_data;
                baud_s  = 16'd0;
                tx_s    = 1'b0;
                state_s = START;
            end
            START: begin
                if (baud_end_s) begin
                    baud_s  = 16'd0;
                    bit_s   = 3'd0;
                    tx_s    = shift_r[0];
                    state_s = DATA;
                end else begin
                    tx_s = 1'b0;
                end
            end
            DATA: begin
                if (baud_end_s) begin
                    baud_s = 16'd0;
                    if (bit_r == 3'd7) begin
                        bit_s = 3'd0;
`ifdef UART_TX_PARITY_EN
                        tx_s    = even_parity(shift_r);
                        state_s = PARITY;
`else
                        tx_s    = 1'b1;
                        state_s = STOP;
`endif
                    end else begin
                        bit_s = bit_inc_s;
                        tx_s  = shift_r[bit_inc_s];
                    end
                end else begin
                    tx_s = shift_r[bit_r];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end_s) begin
                    baud_s  = 16'd0;
                    tx_s    = 1'b1;
                    state_s = STOP;
                end else begin
                    tx_s = even_parity(shift_r);
                end
            end
`endif
            STOP: begin
                if (baud_end_s) begin
                    baud_s  = 16'd0;
                    state_s = IDLE;
                end else begin
                    state_s = STOP;
                end
                tx_s = 1'b1;
            end
            default: begin
                state_s = IDLE;
                baud_s  = 16'd0;
                bit_s   = 3'd0;
                tx_s    = 1'b1;
            end
        endcase
    end

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            baud_r  <= 16'd0;
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            tx_r    <= tx_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    assign q_re = q_re_s;
    assign tx   = tx_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with CLKS_PER_BIT=4; frame tables are hand-computed.
// Expected frames follow UART_TX_PARITY_EN when the bench is built with it.
module tb_uart_tx_drain;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;
    localparam int P  = FL + 2;

    logic       clk;
    logic       rst;
    logic       q_avail;
    logic       q_re;
    logic [7:0] q_data;
    logic       tx;
    logic       busy;

    uart_tx_drain #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst    (rst),
        .q_avail(q_avail),
        .q_re   (q_re),
        .q_data (q_data),
        .tx     (tx),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // frame bit 0 = start, 1..8 = data LSB first, then (parity,) stop
    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame10;
        logic [10:0] frame11;
    } fvec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] qmem [0:15];
    int         qwr = 0;
    int         qptr = 0;
    logic       pop_seen = 1'b0;
    logic       s_qre;
    logic       s_tx;
    logic       s_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b);
        qmem[qwr] = b;
        qwr++;
    endtask

    // One clock: apply queue read data for a pop in the previous cycle, drive inputs, sample mid-cycle
    task automatic cycle(input logic avail, input logic rst_v);
        @(posedge clk);
        #1;
        if (pop_seen) begin
            q_data = qmem[qptr];
            qptr++;
        end
        q_avail = avail;
        rst     = rst_v;
        #3;
        s_qre    = q_re;
        s_tx     = tx;
        s_busy   = busy;
        pop_seen = s_qre;
    endtask

    function automatic logic [10:0] pick(input fvec_t v);
`ifdef UART_TX_PARITY_EN
        return v.frame11;
`else
        return v.frame10;
`endif
    endfunction

    task automatic frame_body(input logic [10:0] fr, input logic avail_fetch, input string tag);
        cycle(avail_fetch, 1'b0);
        check({tag, "_fetch_qre"}, 32'(s_qre), 32'd0);
        check({tag, "_fetch_busy"}, 32'(s_busy), 32'd1);
        check({tag, "_fetch_tx"}, 32'(s_tx), 32'd1);
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < CPB; k++) begin
                cycle(1'b0, 1'b0);
                check({tag, "_tx"}, 32'(s_tx), 32'(fr[b]));
                check({tag, "_busy"}, 32'(s_busy), 32'd1);
                check({tag, "_qre"}, 32'(s_qre), 32'd0);
            end
        end
        cycle(1'b0, 1'b0);
        check({tag, "_end_busy"}, 32'(s_busy), 32'd0);
        check({tag, "_end_tx"}, 32'(s_tx), 32'd1);
        check({tag, "_end_qre"}, 32'(s_qre), 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [10:0] fr, input logic avail_fetch, input string tag);
        push(d);
        cycle(1'b1, 1'b0);
        check({tag, "_pop_qre"}, 32'(s_qre), 32'd1);
        check({tag, "_pop_tx"}, 32'(s_tx), 32'd1);
        check({tag, "_pop_busy"}, 32'(s_busy), 32'd0);
        frame_body(fr, avail_fetch, tag);
    endtask

    fvec_t      vecs [0:5];
    fvec_t      fa5;
    fvec_t      f3c;
    fvec_t      fff;
    logic [10:0] fr;
    logic       exp_qre;
    logic       exp_busy;
    logic       exp_tx;
    int         j;

    initial begin
        vecs[0] = '{8'h55, 11'h2AA, 11'h4AA};
        vecs[1] = '{8'h07, 11'h20E, 11'h60E};
        vecs[2] = '{8'hFF, 11'h3FE, 11'h5FE};
        vecs[3] = '{8'h00, 11'h200, 11'h400};
        vecs[4] = '{8'h80, 11'h300, 11'h700};
        vecs[5] = '{8'h01, 11'h202, 11'h602};
        fa5     = '{8'hA5, 11'h34A, 11'h54A};
        f3c     = '{8'h3C, 11'h278, 11'h478};
        fff     = vecs[2];

        rst     = 1'b1;
        q_avail = 1'b0;
        q_data  = 8'h00;

        // reset held with q_avail high: no pop, idle outputs
        cycle(1'b1, 1'b1);
        check("rst_qre0", 32'(s_qre), 32'd0);
        cycle(1'b1, 1'b1);
        check("rst_qre1", 32'(s_qre), 32'd0);
        check("rst_tx", 32'(s_tx), 32'd1);
        check("rst_busy", 32'(s_busy), 32'd0);

        for (int i = 0; i < 50; i++) begin
            cycle(1'b0, 1'b0);
            check("idle_qre", 32'(s_qre), 32'd0);
            check("idle_tx", 32'(s_tx), 32'd1);
            check("idle_busy", 32'(s_busy), 32'd0);
        end

        // table of single frames; odd entries keep q_avail high through FETCH
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0);
            check("gap_qre", 32'(s_qre), 32'd0);
            run_frame(vecs[i].data, pick(vecs[i]), 1'(i % 2), "frame");
        end

        // back-to-back frames with q_avail held high until the second pop
        push(fa5.data);
        push(f3c.data);
        for (int i = 0; i <= 2 * P + 1; i++) begin
            cycle((i <= P) ? 1'b1 : 1'b0, 1'b0);
            j        = i % P;
            fr       = (i < P) ? pick(fa5) : pick(f3c);
            exp_qre  = (i == 0) || (i == P);
            exp_busy = (i < 2 * P) && (j != 0);
            exp_tx   = ((i < 2 * P) && (j >= 2)) ? fr[(j - 2) / CPB] : 1'b1;
            check("b2b_qre", 32'(s_qre), 32'(exp_qre));
            check("b2b_busy", 32'(s_busy), 32'(exp_busy));
            check("b2b_tx", 32'(s_tx), 32'(exp_tx));
        end

        // reset in the middle of DATA bit 3, q_avail high throughout recovery
        push(8'h00);
        cycle(1'b1, 1'b0);
        check("abort_pop_qre", 32'(s_qre), 32'd1);
        cycle(1'b0, 1'b0);
        for (int n = 0; n < 4 * CPB + 2; n++) begin
            cycle(1'b0, 1'b0);
        end
        check("abort_bit3_tx", 32'(s_tx), 32'd0);
        push(fff.data);
        cycle(1'b1, 1'b1);
        check("abort_rst_qre", 32'(s_qre), 32'd0);
        check("abort_rst_tx", 32'(s_tx), 32'd0);
        cycle(1'b1, 1'b0);
        check("abort_after_tx", 32'(s_tx), 32'd1);
        check("abort_after_busy", 32'(s_busy), 32'd0);
        check("abort_after_qre", 32'(s_qre), 32'd1);
        frame_body(pick(fff), 1'b0, "abort_next");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
